// File: rtl/interrupt_latch_ctrl.sv
// Four-line interrupt latch with fixed priority and a non-preemptive
// serve/acknowledge handshake followed by a programmable quiet gap.
module interrupt_latch_ctrl #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic       ack,
    output logic       irq,
    output logic [1:0] id,
    output logic [3:0] pending,
    output logic [3:0] overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] req_q;
    logic [3:0] rise;
    logic [3:0] eligible;
    logic [3:0] clr;
    logic [3:0] pending_nxt;
    logic [3:0] overrun_nxt;
    logic [1:0] sel;
    logic [1:0] id_nxt;
    logic       irq_nxt;
    logic [3:0] gap_cnt;
    logic [3:0] gap_nxt;

    // Edge detection, priority pick and pending/overrun bookkeeping.
    // A rise on the bit being acknowledged re-arms it and is not an overrun.
    always_comb begin
        rise     = req & ~req_q;
        eligible = pending & ~mask;
        if (eligible[3])      sel = 2'd3;
        else if (eligible[2]) sel = 2'd2;
        else if (eligible[1]) sel = 2'd1;
        else                  sel = 2'd0;
        clr = '0;
        if (state == SERVE && ack) clr[id] = 1'b1;
        pending_nxt = (pending & ~clr) | rise;
        overrun_nxt = overrun | (rise & pending & ~clr);
    end

    // Next-state and next-output logic for the serve handshake.
    always_comb begin
        state_nxt = state;
        irq_nxt   = irq;
        id_nxt    = id;
        gap_nxt   = gap_cnt;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    state_nxt = SERVE;
                    irq_nxt   = 1'b1;
                    id_nxt    = sel;
                end
            end
            SERVE: begin
                if (ack) begin
                    state_nxt = GAP;
                    irq_nxt   = 1'b0;
                    gap_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
                else               gap_nxt   = gap_cnt - 4'd1;
            end
            default: begin
                state_nxt = IDLE;
                irq_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            irq     <= 1'b0;
            id      <= '0;
            pending <= '0;
            overrun <= '0;
            busy    <= 1'b0;
            req_q   <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            irq     <= irq_nxt;
            id      <= id_nxt;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            busy    <= (state_nxt != IDLE);
            req_q   <= req;
            gap_cnt <= gap_nxt;
        end
    end

endmodule

// File: tb/tb_interrupt_latch_ctrl.sv
// Bench for interrupt_latch_ctrl: two instances (gap of 1 and 3 cycles)
// share stimulus and are compared against a cycle-level behavioural model.
module tb_interrupt_latch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;

    logic       irq_o  [2];
    logic [1:0] id_o   [2];
    logic [3:0] pend_o [2];
    logic [3:0] ovr_o  [2];
    logic       busy_o [2];

    int unsigned gap_of [2] = '{1, 3};

    // model state
    logic       m_irq  [2];
    int         m_id   [2];
    int         m_gap  [2];
    logic [3:0] m_pend [2];
    logic [3:0] m_ovr  [2];
    logic [3:0] m_prev;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    interrupt_latch_ctrl #(.GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
        .irq(irq_o[0]), .id(id_o[0]), .pending(pend_o[0]),
        .overrun(ovr_o[0]), .busy(busy_o[0])
    );

    interrupt_latch_ctrl #(.GAP_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
        .irq(irq_o[1]), .id(id_o[1]), .pending(pend_o[1]),
        .overrun(ovr_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behaviour described as: rising edges latch, acks retire the served
    // line, the server idles for a fixed number of cycles after each ack.
    task automatic model_edge(input logic r, input logic [3:0] rq,
                              input logic [3:0] mk, input logic a);
        logic [3:0] rise;
        logic [3:0] old;
        logic       cleared;
        rise = rq & ~m_prev;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_irq[k] = 1'b0; m_id[k] = 0; m_gap[k] = 0;
                m_pend[k] = '0; m_ovr[k] = '0;
            end else begin
                old = m_pend[k];
                for (int i = 0; i < 4; i++) begin
                    cleared = m_irq[k] && a && (m_id[k] == i);
                    if (rise[i]) begin
                        if (old[i] && !cleared) m_ovr[k][i] = 1'b1;
                        m_pend[k][i] = 1'b1;
                    end else if (cleared) begin
                        m_pend[k][i] = 1'b0;
                    end
                end
                if (m_irq[k]) begin
                    if (a) begin
                        m_irq[k] = 1'b0;
                        m_gap[k] = int'(gap_of[k]);
                    end
                end else if (m_gap[k] > 0) begin
                    m_gap[k]--;
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (old[i] && !mk[i]) begin
                            m_irq[k] = 1'b1;
                            m_id[k]  = i;
                        end
                end
            end
        end
        m_prev = r ? 4'b0000 : rq;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("irq[%0d]", k), {3'b0, irq_o[k]}, {3'b0, m_irq[k]});
            if (m_irq[k])
                chk($sformatf("id[%0d]", k), {2'b0, id_o[k]}, 4'(m_id[k]));
            chk($sformatf("pending[%0d]", k), pend_o[k], m_pend[k]);
            chk($sformatf("overrun[%0d]", k), ovr_o[k], m_ovr[k]);
            chk($sformatf("busy[%0d]", k), {3'b0, busy_o[k]},
                {3'b0, (m_irq[k] || m_gap[k] > 0)});
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] mk, input logic a);
        rst = r; req = rq; mask = mk; ack = a;
        @(posedge clk);
        model_edge(r, rq, mk, a);
        #1;
        check_all();
    endtask

    logic [3:0] rq_r;
    logic [3:0] mk_r;

    initial begin
        m_prev = '0;
        for (int k = 0; k < 2; k++) begin
            m_irq[k] = 1'b0; m_id[k] = 0; m_gap[k] = 0;
            m_pend[k] = '0; m_ovr[k] = '0;
        end
        rst = 1'b1; req = '0; mask = '0; ack = 1'b0;
        #2;

        // reset
        step(1, 4'h0, 4'h0, 0);
        step(1, 4'h0, 4'h0, 0);
        chk("rst_id", {2'b0, id_o[0]}, 4'h0);
        chk("rst_irq", {3'b0, irq_o[0]}, 4'h0);

        // single request
        step(0, 4'b0001, 4'h0, 0);
        chk("single_pend", pend_o[0], 4'b0001);
        chk("single_irq0", {3'b0, irq_o[0]}, 4'h0);
        step(0, 4'b0000, 4'h0, 0);
        chk("single_irq", {3'b0, irq_o[0]}, 4'h1);
        chk("single_id", {2'b0, id_o[0]}, 4'h0);
        step(0, 4'b0000, 4'h0, 1);
        chk("single_ack_pend", pend_o[0], 4'b0000);
        chk("single_gap_busy", {3'b0, busy_o[0]}, 4'h1);
        step(0, 4'b0000, 4'h0, 0);
        chk("single_idle_busy", {3'b0, busy_o[0]}, 4'h0);
        repeat (3) step(0, 4'b0000, 4'h0, 0);

        // priority 0110
        step(0, 4'b0110, 4'h0, 0);
        step(0, 4'b0110, 4'h0, 0);
        chk("prio_id_first", {2'b0, id_o[0]}, 4'h2);
        step(0, 4'b0000, 4'h0, 1);
        chk("prio_pend_mid", pend_o[0], 4'b0010);
        step(0, 4'b0000, 4'h0, 0);
        step(0, 4'b0000, 4'h0, 0);
        chk("prio_id_second", {2'b0, id_o[0]}, 4'h1);
        chk("prio_irq_second", {3'b0, irq_o[0]}, 4'h1);
        step(0, 4'b0000, 4'h0, 1);
        repeat (5) step(0, 4'b0000, 4'h0, 0);
        step(0, 4'b0000, 4'h0, 1);

        // preemption blocked, ack ignored in idle
        step(0, 4'b0001, 4'h0, 0);
        step(0, 4'b0001, 4'h0, 0);
        step(0, 4'b1001, 4'h0, 0);
        step(0, 4'b1001, 4'h0, 0);
        chk("nopreempt_id", {2'b0, id_o[0]}, 4'h0);
        step(0, 4'b0000, 4'h0, 1);
        step(0, 4'b0000, 4'h0, 1);
        step(0, 4'b0000, 4'h0, 0);
        chk("after_gap_id", {2'b0, id_o[0]}, 4'h3);
        step(0, 4'b0000, 4'h0, 1);
        repeat (5) step(0, 4'b0000, 4'h0, 0);

        // mask holds irq off, unmask releases it; mask in SERVE has no effect
        step(0, 4'b1000, 4'b1000, 0);
        step(0, 4'b1000, 4'b1000, 0);
        step(0, 4'b1000, 4'b1000, 0);
        chk("mask_irq", {3'b0, irq_o[0]}, 4'h0);
        chk("mask_pend", pend_o[0], 4'b1000);
        step(0, 4'b1000, 4'b0000, 0);
        chk("unmask_id", {2'b0, id_o[0]}, 4'h3);
        step(0, 4'b1000, 4'b1111, 0);
        step(0, 4'b0000, 4'b1111, 1);
        repeat (5) step(0, 4'b0000, 4'b0000, 0);

        // overrun and same-cycle clear/rise collision
        step(0, 4'b0010, 4'h0, 0);
        step(0, 4'b0000, 4'h0, 0);
        step(0, 4'b0010, 4'h0, 0);
        chk("overrun", ovr_o[0], 4'b0010);
        step(0, 4'b0000, 4'h0, 0);
        step(0, 4'b0010, 4'h0, 1);
        chk("collide_pend", pend_o[0], 4'b0010);
        chk("collide_ovr", ovr_o[0], 4'b0010);
        repeat (3) step(0, 4'b0000, 4'h0, 0);
        step(0, 4'b0000, 4'h0, 1);
        repeat (5) step(0, 4'b0000, 4'h0, 0);

        // reset mid-serve with req held high
        step(0, 4'b0100, 4'h0, 0);
        step(0, 4'b0100, 4'h0, 0);
        step(1, 4'b0100, 4'h0, 0);
        chk("rst_mid_irq", {3'b0, irq_o[0]}, 4'h0);
        chk("rst_mid_ovr", ovr_o[0], 4'h0);
        step(0, 4'b0100, 4'h0, 0);
        chk("post_rst_pend", pend_o[0], 4'b0100);
        step(0, 4'b0100, 4'h0, 1);

        // randomized traffic
        rq_r = '0;
        mk_r = '0;
        for (int n = 0; n < 600; n++) begin
            rq_r = rq_r ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) mk_r = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 79) == 0), rq_r, mk_r,
                 ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
